// File: rtl/mic_pitch_reader_if.sv
// Audio-in handshake between Audio_Controller (master) and a sample consumer (slave).
interface mic_pitch_reader_if;
   logic        audio_in_available;
   logic [31:0] left_channel_audio_in;
   logic [31:0] right_channel_audio_in;
   logic        read_audio_in;

   modport master (output audio_in_available, output left_channel_audio_in,
                   output right_channel_audio_in, input read_audio_in);
   modport slave  (input audio_in_available, input left_channel_audio_in,
                   input right_channel_audio_in, output read_audio_in);
endinterface

// File: rtl/mic_pitch_reader.sv
// Drains mic samples, mixes to mono, measures pitch period via hysteretic rising
// zero-crossings, and reports a windowed peak amplitude.
module mic_pitch_reader #(
   parameter logic [31:0] THRESH         = 32'd50000000,
   parameter logic [31:0] MIN_PERIOD     = 32'd25000,
   parameter logic [31:0] MAX_PERIOD     = 32'd1000000,
   parameter logic [15:0] WINDOW_SAMPLES = 16'd4800
) (
   input  logic                      clock,
   input  logic                      reset,
   mic_pitch_reader_if.slave         audio,
   output logic [31:0]               period,
   output logic                      period_valid,
   output logic [31:0]               peak,
   output logic                      signal_present
);

   typedef enum logic {IDLE = 1'b0, HOLD = 1'b1} rd_state_e;
   typedef enum logic {POL_NEG = 1'b0, POL_POS = 1'b1} pol_e;

   localparam logic signed [31:0] THRESH_S = THRESH;
   localparam logic [31:0]        CNT_SAT  = MAX_PERIOD + 32'd1;

   rd_state_e          state_q, state_d;
   logic signed [31:0] left_q, left_d, right_q, right_d;
   logic               lat_v_q, lat_v_d;
   logic signed [31:0] mono_q, mono_d;
   logic               mono_v_q, mono_v_d;
   pol_e               pol_q, pol_d;
   logic               armed_q, armed_d;
   logic [31:0]        cnt_q, cnt_d;
   logic [15:0]        win_q, win_d;
   logic [31:0]        run_max_q, run_max_d;
   logic [31:0]        period_q, period_d;
   logic               period_valid_q, period_valid_d;
   logic [31:0]        peak_q, peak_d;
   logic               sig_q, sig_d;

   logic               rise, fall, in_range;
   logic [31:0]        abs_v, max_v;

   // NOTE: every signal gets a default before the case/if so no path leaves it unassigned (no latches).
   always_comb begin
      state_d             = state_q;
      left_d              = left_q;
      right_d             = right_q;
      lat_v_d             = 1'b0;
      audio.read_audio_in = 1'b0;
      unique case (state_q)
         IDLE: if (audio.audio_in_available) begin
            audio.read_audio_in = 1'b1;
            left_d              = audio.left_channel_audio_in;
            right_d             = audio.right_channel_audio_in;
            lat_v_d             = 1'b1;
            state_d             = HOLD;
         end
         HOLD:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      mono_d   = lat_v_q ? (left_q >>> 1) + (right_q >>> 1) : mono_q;
      mono_v_d = lat_v_q;

      rise     = mono_v_q && (pol_q == POL_NEG) && (mono_q > THRESH_S);
      fall     = mono_v_q && (pol_q == POL_POS) && (mono_q < -THRESH_S);
      in_range = (cnt_q >= MIN_PERIOD) && (cnt_q <= MAX_PERIOD);

      pol_d          = rise ? POL_POS : (fall ? POL_NEG : pol_q);
      cnt_d          = rise ? 32'd1 : ((cnt_q == CNT_SAT) ? cnt_q : cnt_q + 32'd1);
      armed_d        = armed_q;
      sig_d          = sig_q;
      period_d       = period_q;
      period_valid_d = 1'b0;

      if (cnt_q == CNT_SAT) begin
         sig_d   = 1'b0;
         armed_d = 1'b0;
      end
      // A crossing always starts a fresh measurement, so it re-arms even on timeout.
      if (rise) begin
         if (armed_q && in_range) begin
            period_d       = cnt_q;
            period_valid_d = 1'b1;
            sig_d          = 1'b1;
         end
         armed_d = 1'b1;
      end

      abs_v     = mono_q[31] ? -mono_q : mono_q;
      max_v     = (abs_v > run_max_q) ? abs_v : run_max_q;
      run_max_d = run_max_q;
      win_d     = win_q;
      peak_d    = peak_q;
      if (mono_v_q) begin
         if (win_q == WINDOW_SAMPLES - 16'd1) begin
            peak_d    = max_v;
            run_max_d = 32'd0;
            win_d     = 16'd0;
         end else begin
            run_max_d = max_v;
            win_d     = win_q + 16'd1;
         end
      end
   end

   // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clock) begin
      if (reset) begin
         state_q        <= IDLE;
         left_q         <= '0;
         right_q        <= '0;
         lat_v_q        <= 1'b0;
         mono_q         <= '0;
         mono_v_q       <= 1'b0;
         pol_q          <= POL_NEG;
         armed_q        <= 1'b0;
         cnt_q          <= '0;
         win_q          <= '0;
         run_max_q      <= '0;
         period_q       <= '0;
         period_valid_q <= 1'b0;
         peak_q         <= '0;
         sig_q          <= 1'b0;
      end else begin
         state_q        <= state_d;
         left_q         <= left_d;
         right_q        <= right_d;
         lat_v_q        <= lat_v_d;
         mono_q         <= mono_d;
         mono_v_q       <= mono_v_d;
         pol_q          <= pol_d;
         armed_q        <= armed_d;
         cnt_q          <= cnt_d;
         win_q          <= win_d;
         run_max_q      <= run_max_d;
         period_q       <= period_d;
         period_valid_q <= period_valid_d;
         peak_q         <= peak_d;
         sig_q          <= sig_d;
      end
   end

   assign period         = period_q;
   assign period_valid   = period_valid_q;
   assign peak           = peak_q;
   assign signal_present = sig_q;

endmodule

// File: tb/tb_mic_pitch_reader.sv
// Scoreboard bench for mic_pitch_reader with scaled-down period/window parameters.
module tb_mic_pitch_reader;

   localparam int          MIN_P = 2000;
   localparam int          MAX_P = 10000;
   localparam int          WIN   = 48;
   localparam longint      THR   = 64'd50000000;
   localparam logic [31:0] AMP   = 32'd300000000;
   localparam logic [31:0] LOW   = 32'd40000000;

   typedef struct {
      int          due;
      logic [31:0] val;
   } exp_t;

   logic        clock = 1'b0;
   logic        reset = 1'b1;
   logic [31:0] period, peak;
   logic        period_valid, signal_present;

   int   cyc = 0, n_checks = 0, n_fail = 0, pv_seen = 0;
   exp_t pv_q[$];
   exp_t pk_q[$];

   int          m_load, m_win;
   bit          m_pol, m_armed;
   longint      m_run;
   logic [31:0] m_peak, m_period;

   mic_pitch_reader_if bus ();

   mic_pitch_reader #(
      .MIN_PERIOD    (32'(MIN_P)),
      .MAX_PERIOD    (32'(MAX_P)),
      .WINDOW_SAMPLES(16'(WIN))
   ) dut (
      .clock         (clock),
      .reset         (reset),
      .audio         (bus),
      .period        (period),
      .period_valid  (period_valid),
      .peak          (peak),
      .signal_present(signal_present)
   );

   always #5 clock = ~clock;
   always @(posedge clock) cyc <= cyc + 1;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
      end
   endtask

   task automatic model_reset();
      m_load   = cyc;
      m_win    = 0;
      m_pol    = 1'b0;
      m_armed  = 1'b0;
      m_run    = 0;
      m_peak   = '0;
      m_period = '0;
      pv_q.delete();
      pk_q.delete();
   endtask

   // Reference model: sample read in cycle rc is judged in rc+2, outputs visible in rc+3.
   task automatic model_sample(input int rc, input logic [31:0] l, input logic [31:0] r);
      longint mono, a, gap;
      int     e;
      mono = (longint'($signed(l)) >>> 1) + (longint'($signed(r)) >>> 1);
      e    = rc + 2;
      if (!m_pol && mono > THR) begin
         m_pol = 1'b1;
         gap   = longint'(e - m_load);
         if (gap > MAX_P + 1) gap = MAX_P + 1;
         if (m_armed && gap >= MIN_P && gap <= MAX_P) begin
            m_period = 32'(gap);
            pv_q.push_back('{rc + 3, 32'(gap)});
         end
         m_armed = 1'b1;
         m_load  = e;
      end else if (m_pol && mono < -THR) begin
         m_pol = 1'b0;
      end
      a = (mono < 0) ? -mono : mono;
      pk_q.push_back('{rc + 2, m_peak});
      if (a > m_run) m_run = a;
      m_win++;
      if (m_win == WIN) begin
         m_peak = 32'(m_run);
         m_run  = 0;
         m_win  = 0;
         pk_q.push_back('{rc + 3, m_peak});
      end
   endtask

   always @(negedge clock) begin : monitor
      exp_t x;
      if (pv_q.size() != 0 && pv_q[0].due == cyc) begin
         x = pv_q.pop_front();
         check("pv_pulse", 64'(period_valid), 64'(1));
         check("pv_period", 64'(period), 64'(x.val));
      end else if (period_valid) begin
         check("pv_spurious", 64'(period_valid), 64'(0));
      end
      if (period_valid) pv_seen++;
      while (pk_q.size() != 0 && pk_q[0].due <= cyc) begin
         x = pk_q.pop_front();
         check("peak_sb", 64'(peak), 64'(x.val));
      end
   end

   task automatic send(input logic [31:0] l, input logic [31:0] r, input int spacing);
      int rc;
      @(posedge clock); #1;
      bus.audio_in_available    = 1'b1;
      bus.left_channel_audio_in  = l;
      bus.right_channel_audio_in = r;
      rc = cyc;
      model_sample(rc, l, r);
      @(negedge clock);
      check("read_strobe", 64'(bus.read_audio_in), 64'(1));
      @(posedge clock); #1;
      bus.audio_in_available = 1'b0;
      while (cyc < rc + spacing - 1) begin
         @(posedge clock); #1;
      end
   endtask

   task automatic tone(input int segs, input int per_seg, input logic [31:0] amp,
                       input bit start_pos, input int spacing);
      bit          pos;
      logic [31:0] v;
      pos = start_pos;
      for (int s = 0; s < segs; s++) begin
         v = pos ? amp : -amp;
         for (int i = 0; i < per_seg; i++) send(v, v, spacing);
         pos = !pos;
      end
   endtask

   task automatic do_reset();
      @(posedge clock); #1 reset = 1'b1;
      @(posedge clock); #1 reset = 1'b0;
      model_reset();
      @(negedge clock);
      check("rst_period", 64'(period), 64'(0));
      check("rst_pv", 64'(period_valid), 64'(0));
      check("rst_peak", 64'(peak), 64'(0));
      check("rst_sig", 64'(signal_present), 64'(0));
      check("rst_read", 64'(bus.read_audio_in), 64'(0));
   endtask

   initial begin : watchdog
      #2000000;
      $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
      $fatal(1, "watchdog expired");
   end

   initial begin : stim
      int pops, base, t0;
      bus.audio_in_available     = 1'b0;
      bus.left_channel_audio_in  = '0;
      bus.right_channel_audio_in = '0;
      do_reset();

      // Handshake: available held for 10 cycles yields pops on even cycles only.
      @(posedge clock); #1;
      pops = 0;
      bus.audio_in_available = 1'b1;
      for (int i = 0; i < 10; i++) begin
         if (i % 2 == 0) model_sample(cyc, 32'd0, 32'd0);
         @(negedge clock);
         check("hs_read", 64'(bus.read_audio_in), 64'(i % 2 == 0));
         if (bus.read_audio_in) pops++;
         @(posedge clock); #1;
      end
      bus.audio_in_available = 1'b0;
      check("hs_pops", 64'(pops), 64'(5));

      // Square tone, period 2000 cycles (exactly MIN_P).
      tone(6, 100, AMP, 1'b1, 10);
      check("tone_sig", 64'(signal_present), 64'(1));
      check("tone_period", 64'(period), 64'(2000));

      // Sub-threshold square.
      do_reset();
      base = pv_seen;
      tone(10, 10, LOW, 1'b1, 10);
      check("sub_no_pv", 64'(pv_seen - base), 64'(0));
      check("sub_sig", 64'(signal_present), 64'(0));
      check("sub_peak", 64'(peak), 64'(LOW));

      // Out-of-range fast flips keep the previous period.
      tone(3, 100, AMP, 1'b1, 10);
      base = pv_seen;
      tone(6, 10, AMP, 1'b0, 10);
      check("oor_no_pv", 64'(pv_seen - base), 64'(0));
      check("oor_period", 64'(period), 64'(m_period));
      check("oor_sig", 64'(signal_present), 64'(1));

      // Constant positive input until the counter saturates.
      t0 = m_load;
      fork
         repeat (105) send(AMP, AMP, 100);
         begin
            while (cyc < t0 + MAX_P) @(negedge clock);
            check("timeout_before", 64'(signal_present), 64'(1));
            while (cyc < t0 + MAX_P + 2) @(negedge clock);
            check("timeout_after", 64'(signal_present), 64'(0));
         end
      join

      // Peak extremes: one full-scale negative sample, then an all-zero window.
      while (m_win != 0) send(32'd0, 32'd0, 4);
      for (int i = 0; i < WIN; i++) begin
         if (i == 10) send(32'h8000_0000, 32'h8000_0000, 4);
         else         send(32'd0, 32'd0, 4);
      end
      check("peak_extreme", 64'(peak), 64'(32'h8000_0000));
      for (int i = 0; i < WIN; i++) send(32'd0, 32'd0, 4);
      check("peak_zero", 64'(peak), 64'(0));

      // Reset between crossings of a running tone.
      tone(3, 100, AMP, 1'b1, 10);
      check("pre_rst_period", 64'(period), 64'(2000));
      tone(1, 50, AMP, 1'b0, 10);
      do_reset();
      base = pv_seen;
      tone(1, 50, AMP, 1'b0, 10);
      tone(1, 100, AMP, 1'b1, 10);
      check("post_rst_first", 64'(pv_seen - base), 64'(0));
      tone(2, 100, AMP, 1'b0, 10);
      check("post_rst_second", 64'(pv_seen - base), 64'(1));
      check("post_rst_period", 64'(period), 64'(2000));

      repeat (5) @(posedge clock);
      check("pv_drained", 64'(pv_q.size()), 64'(0));
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
